aes_key_expand_seq: RTL
=======================

Name: aes_key_expand_seq

Overview:
- Sequential AES key-schedule generator, parametrised for AES-128, AES-192 and AES-256.
- Accepts one cipher key over a valid/ready handshake.
- Streams the expanded round-key words w[0..4*(NR+1)-1] one per handshake, in FIPS-197 order.
- Sits between the key register and the round-key store. Reuses the existing aesRotateWord for the RotWord step.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4, 6, 8. Any other value is an elaboration error.
- NR, NK+6, round count (derived; not overridable).
- NWORDS, 4*(NR+1), total words emitted: 44, 52 or 60.

Ports:
- clk  in  1  rising-edge clock.
- rstN  in  1  asynchronous active-low reset.
- keyValid  in  1  key offered.
- keyReady  out  1  block can accept a key.
- keyIn  in  32*NK  cipher key; bits [32*NK-1 -: 32] are w[0].
- wordValid  out  1  wordOut holds a valid schedule word.
- wordReady  in  1  consumer accepts wordOut.
- wordOut  out  32  current schedule word w[wordIndex].
- wordIndex  out  6  index of wordOut, 0..NWORDS-1.
- lastWord  out  1  high with wordValid when wordIndex==NWORDS-1.
- busy  out  1  high in EMIT.

Behaviour:
- Reset: async clear on rstN low.
  - State IDLE; window registers, wordOut and wordIndex at 0.
  - rcon = 8'h01.
  - wordValid, lastWord, busy = 0; keyReady = 1.
- State machine:
  - IDLE: keyReady=1. On keyValid&keyReady:
    - load keyIn into an NK-word sliding window;
    - wordOut <= w[0], wordIndex <= 0, modCnt <= 0;
    - go to EMIT.
  - EMIT: wordValid=1, keyReady=0. keyValid is ignored.
- Latency: w[0] is valid the cycle after key acceptance.
  - Each wordValid&wordReady presents the next word in the following cycle.
  - Sustained throughput is 1 word/cycle.
- Stall: while wordValid & !wordReady, wordOut, wordIndex, lastWord, the window and rcon hold stable.
- Word generation:
  - Indices 0..NK-1 come straight from the key.
  - For i>=NK: temp=w[i-1].
    - If i mod NK==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <= xtime(rcon). xtime: 8'h80 -> 8'h1b, otherwise shift left by 1.
    - Else if NK==8 and i mod NK==4: temp = SubWord(temp).
    - Result: w[i] = w[i-NK] ^ temp.
- Index tracking: i mod NK comes from the modCnt counter (wraps at NK-1). No divider is used.
- Window update: on each handshake the window shifts out the oldest word and takes in the new one.
- Final word: handshake on the word with lastWord=1 returns to IDLE. keyReady=1 and wordValid=0 on the next cycle.
- Back-to-back keys: a new key is accepted no earlier than the first IDLE cycle.
- Reset mid-EMIT: immediate async return to reset values. No partial output follows.

Optional Feature:
- Macro: KEYEXP_ABORT_EN.
- Defined:
  - adds input abort (1 bit);
  - abort high in EMIT forces IDLE on the next edge and clears wordValid, lastWord and busy;
  - rcon resets to 8'h01;
  - abort has priority over a simultaneous wordReady handshake;
  - abort in IDLE has no effect.
- Undefined: no abort port. EMIT leaves only via the final handshake or reset.

Decomposition:
- Package aes_keyexp_pkg holds:
  - state enum {IDLE, EMIT};
  - legal NK constants;
  - function nwords(NK);
  - function xtime8;
  - RCON_INIT = 8'h01.
- Sub-module aes_sub_word: combinational 4-byte S-box substitution on a 32-bit word.
- The existing aesRotateWord is instantiated with disableRotate=1'b0.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, wordReady tied 1:
  - w[0]=2b7e1516, w[4]=a0fafe17, w[43]=b6630ca6;
  - lastWord only at index 43;
  - keyReady high the cycle after.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: w[6]=fe0c91f7, w[51]=01002202, 52 words total.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - w[8]=9ba35411;
  - w[12]=a8b09c1a (SubWord-only path);
  - w[59]=706c631e.
- Backpressure: random wordReady with ~40% duty gives the identical word sequence. Outputs hold while stalled. keyValid pulses during EMIT are ignored.
- Reset mid-stream:
  - drop rstN at wordIndex=17; all outputs cleared asynchronously;
  - a new key afterwards regenerates from w[0] with rcon=01.
- KEYEXP_ABORT_EN builds only:
  - abort at wordIndex=10 together with wordReady gives wordValid=0 next cycle and keyReady=1;
  - a reload of the same key reproduces w[4]=a0fafe17.

Source files
------------

// File: rtl/aes_keyexp_pkg.sv
// Shared types, constants and helpers for the sequential AES key-schedule generator.
package aes_keyexp_pkg;

    // Controller states: waiting for a key, or streaming schedule words.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Legal key lengths in 32-bit words (AES-128/192/256).
    localparam int NK_128 = 4;
    localparam int NK_192 = 6;
    localparam int NK_256 = 8;

    // First round constant of every schedule.
    localparam logic [7:0] RCON_INIT = 8'h01;

    // Number of schedule words produced for a key of nk words: 4*(NR+1), NR = nk+6.
    function automatic int nwords(input int nk);
        return 4 * (nk + 7);
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1 (8'h80 -> 8'h1b).
    function automatic logic [7:0] xtime8(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aesRotateWord.sv
// RotWord step of the AES key schedule: cyclic left rotation by one byte.
// disableRotate passes the word through unchanged.
module aesRotateWord (
    input  logic [31:0] inWord,
    input  logic        disableRotate,
    output logic [31:0] outWord
);

    // Byte rotation {a0,a1,a2,a3} -> {a1,a2,a3,a0}, or bypass.
    always_comb begin
        outWord = disableRotate ? inWord : {inWord[23:0], inWord[31:24]};
    end

endmodule

// File: rtl/aes_sub_word.sv
// SubWord step of the AES key schedule: applies the AES S-box to each byte.
// The S-box is computed as the GF(2^8) inverse followed by the affine map,
// which keeps the source free of a 256-entry table.
module aes_sub_word
    import aes_keyexp_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // Exponent giving the multiplicative inverse: a^254 = a^-1 (and 0 -> 0).
    localparam logic [7:0] INV_EXP = 8'd254;

    // Shift-and-add multiply in GF(2^8).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ aa;
            aa = xtime8(aa);
        end
        return acc;
    endfunction

    // S-box: inverse by square-and-multiply, then the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        inv  = 8'h01;
        base = x;
        for (int k = 0; k < 8; k++) begin
            if (INV_EXP[k]) inv = gf_mul(inv, base);
            base = gf_mul(base, base);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    // Four independent byte substitutions.
    always_comb begin
        word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                    sbox(word_in[15:8]),  sbox(word_in[7:0])};
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key-schedule generator (AES-128/192/256 selected by NK).
// Takes one cipher key over keyValid/keyReady and streams w[0..NWORDS-1],
// one word per wordValid/wordReady handshake, in FIPS-197 order.
// Optional build macro KEYEXP_ABORT_EN adds an 'abort' input that drops an
// in-progress schedule and returns to IDLE.
module aes_key_expand_seq
    import aes_keyexp_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic            clk,
    input  logic            rstN,
`ifdef KEYEXP_ABORT_EN
    input  logic            abort,
`endif
    input  logic            keyValid,
    output logic            keyReady,
    input  logic [32*NK-1:0] keyIn,
    output logic            wordValid,
    input  logic            wordReady,
    output logic [31:0]     wordOut,
    output logic [5:0]      wordIndex,
    output logic            lastWord,
    output logic            busy
);

    localparam int NR     = NK + 6;
    localparam int NWORDS = nwords(NK);

    // Only the three AES key lengths are meaningful.
    if (NK != NK_128 && NK != NK_192 && NK != NK_256) begin : g_bad_nk
        $error("aes_key_expand_seq: NK must be 4, 6 or 8");
    end
    if (NWORDS != 4 * (NR + 1)) begin : g_bad_nwords
        $error("aes_key_expand_seq: inconsistent word count");
    end

    state_e      state_q, state_d;
    logic [31:0] window_q [NK];   // last NK schedule words, [0] oldest
    logic [31:0] window_d [NK];
    logic [31:0] word_q, word_d;
    logic [5:0]  idx_q, idx_d;
    logic [2:0]  mod_q, mod_d;    // wordIndex mod NK, kept by counting
    logic [7:0]  rcon_q, rcon_d;

    logic        abort_req;
    logic        mod_wrap;
    logic [31:0] rot_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp_word;
    logic [31:0] gen_word;

`ifdef KEYEXP_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // The word after w[idx] has index (idx+1); it starts a new NK block when
    // the current word sits at position NK-1 of its block.
    assign mod_wrap = (mod_q == 3'(NK - 1));

    aesRotateWord u_rotate (
        .inWord        (window_q[NK-1]),
        .disableRotate (1'b0),
        .outWord       (rot_word)
    );

    aes_sub_word u_sub_word (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    // Next schedule word from the window: w[i] = w[i-NK] ^ f(w[i-1]).
    always_comb begin
        sub_in    = mod_wrap ? rot_word : window_q[NK-1];
        temp_word = window_q[NK-1];
        if (mod_wrap) begin
            temp_word = sub_out ^ {rcon_q, 24'h000000};
        end else if (NK == NK_256 && mod_q == 3'd3) begin
            temp_word = sub_out;
        end
        gen_word = window_q[0] ^ temp_word;
    end

    // Next-state and datapath update for key load, word advance and exit.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d  = state_q;
        window_d = window_q;
        word_d   = word_q;
        idx_d    = idx_q;
        mod_d    = mod_q;
        rcon_d   = rcon_q;
        case (state_q)
            IDLE: begin
                if (keyValid) begin
                    for (int k = 0; k < NK; k++) begin
                        window_d[k] = keyIn[32*(NK-k)-1 -: 32];
                    end
                    word_d  = keyIn[32*NK-1 -: 32];
                    idx_d   = '0;
                    mod_d   = '0;
                    rcon_d  = RCON_INIT;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (abort_req) begin
                    state_d = IDLE;
                    rcon_d  = RCON_INIT;
                end else if (wordReady) begin
                    if (idx_q == 6'(NWORDS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                        mod_d = mod_wrap ? 3'd0 : mod_q + 3'd1;
                        if (idx_q < 6'(NK - 1)) begin
                            // Still inside the key: next word is already in the window.
                            for (int k = 1; k < NK; k++) begin
                                if (idx_q == 6'(k - 1)) word_d = window_q[k];
                            end
                        end else begin
                            word_d = gen_word;
                            for (int k = 0; k < NK - 1; k++) begin
                                window_d[k] = window_q[k+1];
                            end
                            window_d[NK-1] = gen_word;
                            if (mod_wrap) rcon_d = xtime8(rcon_q);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, window and output registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            // NOTE: the window is a small register array that is reset on purpose: a
            // reset mid-stream must leave no trace of the previous key.
            for (int k = 0; k < NK; k++) window_q[k] <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            mod_q   <= '0;
            rcon_q  <= RCON_INIT;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
            mod_q    <= mod_d;
            rcon_q   <= rcon_d;
        end
    end

    assign keyReady  = (state_q == IDLE);
    assign wordValid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign lastWord  = (state_q == EMIT) && (idx_q == 6'(NWORDS - 1));
    assign wordOut   = word_q;
    assign wordIndex = idx_q;

endmodule
